seg7_scan_capture: RTL and testbench

- Reverse path of the 7-segment encoder: samples the multiplexed, active-low segment bus and digit-select lines driven to the display, and reconstructs the hex value shown on each digit.
- Used as an on-chip display monitor for the clock project: self-check, scoreboard tap, and readback of what is actually being shown.
- A stability filter rejects scan-transition glitches. Captured digits are published per digit, and as a packed frame once every digit has been seen.

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/seg7_decode.sv | 46 ++++
 rtl/seg7_scan_capture.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared segment patterns (active-low, bit6=g .. bit0=a) and
//               digit-select helpers for the 7-segment encoder/capture pair.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int NUM_DIG_DEF = 6;
    localparam int MAX_DIG     = 16;
    localparam int SEL_IDX_W   = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic                 legal;
        logic [SEL_IDX_W-1:0] idx;
    } sel_dec_t;

    // Unused upper bits must be padded with ones (inactive) by the caller.
    function automatic sel_dec_t onehot_low_idx(input logic [MAX_DIG-1:0] sel_n);
        sel_dec_t    res;
        int unsigned n_low;
        res   = '0;
        n_low = 0;
        for (int i = 0; i < MAX_DIG; i++) begin
            if (!sel_n[i]) begin
                n_low++;
                res.idx = SEL_IDX_W'(i);
            end
        end
        res.legal = (n_low == 1);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational inverse of the 7-segment encoder table.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_val,
    output logic       o_hit,
    output logic       o_blank
);

    always_comb begin
        o_val   = 4'h0;
        o_hit   = 1'b1;
        o_blank = 1'b0;
        case (i_seg)
            SEG_0:     o_val = 4'h0;
            SEG_1:     o_val = 4'h1;
            SEG_2:     o_val = 4'h2;
            SEG_3:     o_val = 4'h3;
            SEG_4:     o_val = 4'h4;
            SEG_5:     o_val = 4'h5;
            SEG_6:     o_val = 4'h6;
            SEG_7:     o_val = 4'h7;
            SEG_8:     o_val = 4'h8;
            SEG_9:     o_val = 4'h9;
            SEG_A:     o_val = 4'hA;
            SEG_B:     o_val = 4'hB;
            SEG_C:     o_val = 4'hC;
            SEG_D:     o_val = 4'hD;
            SEG_E:     o_val = 4'hE;
            SEG_F:     o_val = 4'hF;
            SEG_BLANK: begin
                o_hit   = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_hit = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_capture
// Description : Samples the multiplexed active-low segment/select bus, filters
//               scan glitches and reconstructs per-digit values and frames.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIG    = NUM_DIG_DEF,
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic [6:0]           i_seg,
    input  logic [NUM_DIG-1:0]   i_sel,
    output logic [4*NUM_DIG-1:0] o_digits,
    output logic [NUM_DIG-1:0]   o_dig_valid,
    output logic [NUM_DIG-1:0]   o_dig_err,
    output logic [NUM_DIG-1:0]   o_blank,
    output logic [4*NUM_DIG-1:0] o_frame,
    output logic                 o_frame_stb,
    output logic                 o_sel_err
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic [6:0]           r_s_seg;
    logic [NUM_DIG-1:0]   r_s_sel;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_committed;
    logic [NUM_DIG-1:0]   r_seen;
    logic [4*NUM_DIG-1:0] r_digits;
    logic [NUM_DIG-1:0]   r_valid;
    logic [NUM_DIG-1:0]   r_err;
    logic [NUM_DIG-1:0]   r_blank;
    logic [4*NUM_DIG-1:0] r_frame;
    logic                 r_frame_stb;
    logic                 r_sel_err;

    logic                 w_same;
    logic                 w_commit;
    logic                 w_cap;
    logic [MAX_DIG-1:0]   w_sel_pad;
    sel_dec_t             w_sel;
    logic [NUM_DIG-1:0]   w_mask;
    logic [3:0]           w_dec_val;
    logic                 w_dec_hit;
    logic                 w_dec_blank;
    logic [3:0]           w_new_val;
    logic                 w_new_err;
    logic [4*NUM_DIG-1:0] w_digits_nxt;
    logic [NUM_DIG-1:0]   w_seen_nxt;
    logic                 w_frame_done;

    seg7_decode u_decode (
        .i_seg   (r_s_seg),
        .o_val   (w_dec_val),
        .o_hit   (w_dec_hit),
        .o_blank (w_dec_blank)
    );

    assign w_same   = ({i_seg, i_sel} == {r_s_seg, r_s_sel});
    assign w_commit = w_same && (r_cnt == C_CNT_MAX) && !r_committed;

    always_comb begin
        w_sel_pad              = '1;
        w_sel_pad[NUM_DIG-1:0] = r_s_sel;
    end

    assign w_sel     = onehot_low_idx(w_sel_pad);
    assign w_cap     = w_commit && w_sel.legal;
    assign w_mask    = w_cap ? (NUM_DIG'(1) << w_sel.idx) : '0;
    assign w_new_val = w_dec_hit ? w_dec_val : 4'h0;
    assign w_new_err = !w_dec_hit && !w_dec_blank;

    always_comb begin
        w_digits_nxt = r_digits;
        for (int d = 0; d < NUM_DIG; d++) begin
            if (w_mask[d]) begin
                w_digits_nxt[4*d +: 4] = w_new_val;
            end
        end
    end

    assign w_seen_nxt   = r_seen | w_mask;
    assign w_frame_done = w_cap && (&w_seen_nxt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_seg     <= '0;
            r_s_sel     <= '0;
            r_cnt       <= '0;
            r_committed <= 1'b0;
            r_seen      <= '0;
            r_digits    <= '0;
            r_valid     <= '0;
            r_err       <= '0;
            r_blank     <= '0;
            r_frame     <= '0;
            r_frame_stb <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (i_clr) begin
            r_s_seg     <= '0;
            r_s_sel     <= '0;
            r_cnt       <= '0;
            r_committed <= 1'b0;
            r_seen      <= '0;
            r_digits    <= '0;
            r_valid     <= '0;
            r_err       <= '0;
            r_blank     <= '0;
            r_frame     <= '0;
            r_frame_stb <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            r_s_seg <= i_seg;
            r_s_sel <= i_sel;
            // Saturating count plus committed flag: a held pattern commits once.
            if (!w_same) begin
                r_cnt       <= '0;
                r_committed <= 1'b0;
            end else begin
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_commit) begin
                    r_committed <= 1'b1;
                end
            end
            r_sel_err   <= w_commit && !w_sel.legal;
            r_frame_stb <= w_frame_done;
            r_digits    <= w_digits_nxt;
            for (int d = 0; d < NUM_DIG; d++) begin
                if (w_mask[d]) begin
                    r_valid[d] <= 1'b1;
                    r_err[d]   <= w_new_err;
                    r_blank[d] <= w_dec_blank;
                end
            end
            if (w_frame_done) begin
                r_frame <= w_digits_nxt;
                r_seen  <= '0;
            end else begin
                r_seen  <= w_seen_nxt;
            end
        end
    end

    assign o_digits    = r_digits;
    assign o_dig_valid = r_valid;
    assign o_dig_err   = r_err;
    assign o_blank     = r_blank;
    assign o_frame     = r_frame;
    assign o_frame_stb = r_frame_stb;
    assign o_sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_capture
// Description : Directed and randomized self-checking bench for the capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;

    localparam int ND     = 6;
    localparam int STABLE = 4;

    logic            clk;
    logic            rst_n;
    logic            clr;
    logic [6:0]      seg;
    logic [ND-1:0]   sel;
    logic [4*ND-1:0] o_digits;
    logic [ND-1:0]   o_dig_valid;
    logic [ND-1:0]   o_dig_err;
    logic [ND-1:0]   o_blank;
    logic [4*ND-1:0] o_frame;
    logic            o_frame_stb;
    logic            o_sel_err;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    seg7_scan_capture #(.NUM_DIG(ND), .STABLE_CYC(STABLE), .CNT_W(3)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clr       (clr),
        .i_seg       (seg),
        .i_sel       (sel),
        .o_digits    (o_digits),
        .o_dig_valid (o_dig_valid),
        .o_dig_err   (o_dig_err),
        .o_blank     (o_blank),
        .o_frame     (o_frame),
        .o_frame_stb (o_frame_stb),
        .o_sel_err   (o_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: run length of identical samples, commit when it reaches STABLE.
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int              m_run;
    logic [12:0]     m_prev;
    logic [3:0]      m_dig [ND];
    logic [ND-1:0]   m_valid, m_err, m_blank, m_seen;
    logic [4*ND-1:0] m_frame;
    logic            m_stb, m_selerr;

    function automatic logic [4*ND-1:0] m_pack();
        logic [4*ND-1:0] p;
        for (int d = 0; d < ND; d++) p[4*d +: 4] = m_dig[d];
        return p;
    endfunction

    task automatic model_reset();
        m_run = 0; m_prev = '0;
        for (int d = 0; d < ND; d++) m_dig[d] = 4'h0;
        m_valid = '0; m_err = '0; m_blank = '0; m_seen = '0;
        m_frame = '0; m_stb = 1'b0; m_selerr = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] s, input logic [ND-1:0] l, input logic c);
        int   n;
        int   v;
        if (c) begin
            model_reset();
            return;
        end
        m_stb = 1'b0; m_selerr = 1'b0;
        if ({s, l} == m_prev) m_run++; else m_run = 0;
        m_prev = {s, l};
        if (m_run == STABLE) begin
            if ($countones(~l) != 1) begin
                m_selerr = 1'b1;
            end else begin
                n = 0; v = -1;
                for (int i = 0; i < ND; i++) if (!l[i]) n = i;
                for (int k = 0; k < 16; k++) if (tbl[k] == s) v = k;
                m_dig[n]   = (v >= 0) ? 4'(v) : 4'h0;
                m_blank[n] = (s == 7'h7F);
                m_err[n]   = (v < 0) && (s != 7'h7F);
                m_valid[n] = 1'b1;
                m_seen[n]  = 1'b1;
                if (&m_seen) begin
                    m_frame = m_pack();
                    m_stb   = 1'b1;
                    m_seen  = '0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("digits",   32'(o_digits),    32'(m_pack()));
            chk("valid",    32'(o_dig_valid), 32'(m_valid));
            chk("err",      32'(o_dig_err),   32'(m_err));
            chk("blank",    32'(o_blank),     32'(m_blank));
            chk("frame",    32'(o_frame),     32'(m_frame));
            chk("frame_stb", 32'(o_frame_stb), 32'(m_stb));
            chk("sel_err",  32'(o_sel_err),   32'(m_selerr));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(seg, sel, clr);
        #1;
    endtask

    task automatic hold(input logic [6:0] s, input logic [ND-1:0] l, input int n);
        seg = s; sel = l;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [ND-1:0] sel_of(input int d);
        logic [ND-1:0] one;
        one = ND'(1) << d;
        return ~one;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int stb_cnt, stb_dig, err_cnt, err_tick;

    initial begin
        rst_n = 1'b0; clr = 1'b0; seg = 7'h40; sel = 6'b111110;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid",  32'(o_dig_valid), 32'h0);
        chk("reset_digits", 32'(o_digits),    32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1. Latency
        for (int i = 0; i < 4; i++) tick();
        chk("lat_edge4_valid", 32'(o_dig_valid), 32'h0);
        tick();
        chk("lat_edge5_valid", 32'(o_dig_valid), 32'h01);
        chk("lat_edge5_dig0",  32'(o_digits[3:0]), 32'h0);

        // 2. Glitch rejection
        hold(7'h24, 6'b111101, 3);
        chk("glitch_no_cap", 32'(o_dig_valid), 32'h01);
        hold(7'h30, 6'b111101, 5);
        chk("glitch_dig1", 32'(o_digits[7:4]), 32'h3);
        chk("glitch_valid", 32'(o_dig_valid), 32'h03);

        // 3. Full frame
        stb_cnt = 0; stb_dig = -1;
        begin
            logic [6:0] pats [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h18};
            for (int d = 0; d < 6; d++) begin
                seg = pats[d]; sel = sel_of(d);
                for (int i = 0; i < 8; i++) begin
                    tick();
                    if (o_frame_stb) begin stb_cnt++; stb_dig = d * 8 + i; end
                end
            end
        end
        chk("frame_stb_count", 32'(stb_cnt), 32'd1);
        chk("frame_stb_when",  32'(stb_dig), 32'(5 * 8 + 4));
        chk("frame_value",     32'(o_frame), 32'h954321);

        // 4. Pattern classes
        hold(7'h7E, sel_of(2), 6);
        chk("class_err2",   32'(o_dig_err[2]),    32'h1);
        chk("class_valid2", 32'(o_dig_valid[2]),  32'h1);
        chk("class_dig2",   32'(o_digits[11:8]),  32'h0);
        hold(7'h7F, sel_of(3), 6);
        chk("class_blank3", 32'(o_blank[3]),   32'h1);
        chk("class_err3",   32'(o_dig_err[3]), 32'h0);
        chk("class_digits", 32'(o_digits), 32'h950021);

        // 5. Illegal select
        err_cnt = 0; err_tick = -1;
        seg = 7'h40; sel = 6'b111100;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_sel_err) begin err_cnt++; err_tick = i + 1; end
        end
        chk("selerr_count",  32'(err_cnt),  32'd1);
        chk("selerr_edge",   32'(err_tick), 32'd5);
        chk("selerr_digits", 32'(o_digits), 32'h950021);

        // 6. Reset mid-hold, then clear coincident with commit
        hold(7'h79, sel_of(0), 3);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_digits", 32'(o_digits),    32'h0);
        chk("arst_valid",  32'(o_dig_valid), 32'h0);
        chk("arst_frame",  32'(o_frame),     32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(7'h79, sel_of(0), 4);
        chk("arst_edge4", 32'(o_dig_valid), 32'h0);
        tick();
        chk("arst_edge5", 32'(o_dig_valid), 32'h01);
        chk("arst_dig0",  32'(o_digits[3:0]), 32'h1);
        hold(7'h40, sel_of(2), 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_valid", 32'(o_dig_valid), 32'h0);
        chk("clr_digits", 32'(o_digits),   32'h0);
        chk("clr_stb",   32'(o_frame_stb), 32'h0);

        // Randomized scan traffic
        for (int e = 0; e < 400; e++) begin
            int r;
            logic [6:0] s;
            logic [ND-1:0] l;
            r = $urandom_range(0, 9);
            if (r < 7)       s = tbl[$urandom_range(0, 15)];
            else if (r == 7) s = 7'h7F;
            else             s = 7'($urandom);
            if ($urandom_range(0, 7) == 0) l = ND'($urandom);
            else                           l = sel_of($urandom_range(0, ND - 1));
            if ($urandom_range(0, 29) == 0) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
            end
            hold(s, l, $urandom_range(1, 9));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
